// File: rtl/mem_map_pkg.sv
// Address map, STAT field layout and bus request payload for the CPU memory bus responder.
package mem_map_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [DATA_W-1:0] RAM_TOP   = 16'h3FFF;
    localparam logic [DATA_W-1:0] ADDR_LED  = 16'hFF00;
    localparam logic [DATA_W-1:0] ADDR_SW   = 16'hFF01;
    localparam logic [DATA_W-1:0] ADDR_CNT  = 16'hFF02;
    localparam logic [DATA_W-1:0] ADDR_FIFO = 16'hFF03;
    localparam logic [DATA_W-1:0] ADDR_STAT = 16'hFF04;

    localparam int unsigned STAT_FULL   = 0;
    localparam int unsigned STAT_EMPTY  = 1;
    localparam int unsigned STAT_OVF    = 2;
    localparam int unsigned STAT_CNT_LO = 3;
    localparam int unsigned STAT_CNT_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic is_ram(input logic [DATA_W-1:0] addr);
        return addr <= RAM_TOP;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is only accepted when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow_pulse
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full           = (cnt_q == CNT_W'(DEPTH));
    assign empty          = (cnt_q == '0);
    assign count          = cnt_q;
    assign head           = mem[rd_ptr];
    assign do_pop         = pop && !empty;
    assign do_push        = push && (!full || do_pop);
    assign overflow_pulse = push && full && !do_pop;

    // Storage is reset so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// CPU memory-bus responder: routes accesses to block RAM or MMIO registers with a uniform
// one-cycle read latency (MMIO read data is registered alongside the RAM's address register).
module mem_bus_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 14,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cpu_addr,
    input  logic                  cpu_we,
    input  logic [15:0]           cpu_wdata,
    output logic [15:0]           cpu_rdata,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic [15:0]           ram_wdata,
    input  logic [15:0]           ram_rdata,
    input  logic [7:0]            sw,
    output logic [7:0]            led,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    bus_req_t              req;
    logic                  sel_ram;
    logic                  wr_led;
    logic                  wr_cnt;
    logic                  wr_fifo;
    logic                  wr_stat;
    logic [BYTE_W-1:0]     sw_meta;
    logic [BYTE_W-1:0]     sw_sync;
    logic [DATA_W-1:0]     cnt_q;
    logic [DATA_W-1:0]     stat_word;
    logic [DATA_W-1:0]     mmio_d;
    logic [DATA_W-1:0]     mmio_q;
    logic                  sel_ram_q;
    logic                  overflow_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_ovf_pulse;
    logic [FIFO_CNT_W-1:0] fifo_count;

    assign req     = '{addr: cpu_addr, we: cpu_we, wdata: cpu_wdata};
    assign sel_ram = is_ram(req.addr);
    assign wr_led  = req.we && (req.addr == ADDR_LED);
    assign wr_cnt  = req.we && (req.addr == ADDR_CNT);
    assign wr_fifo = req.we && (req.addr == ADDR_FIFO);
    assign wr_stat = req.we && (req.addr == ADDR_STAT);

    // RAM path is purely combinational; the RAM registers the address itself.
    assign ram_addr  = RAM_ADDR_W'(req.addr);
    assign ram_wdata = req.wdata;
    assign ram_we    = req.we && sel_ram;

    assign out_valid = !fifo_empty;
    assign cpu_rdata = sel_ram_q ? ram_rdata : mmio_q;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (wr_fifo),
        .push_data      (req.wdata[BYTE_W-1:0]),
        .pop            (out_valid && out_ready),
        .head           (out_data),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .count          (fifo_count),
        .overflow_pulse (fifo_ovf_pulse)
    );

    always_comb begin
        stat_word                                  = '0;
        stat_word[STAT_FULL]                       = fifo_full;
        stat_word[STAT_EMPTY]                      = fifo_empty;
        stat_word[STAT_OVF]                        = overflow_q;
        stat_word[STAT_CNT_LO +: STAT_CNT_W]       = STAT_CNT_W'(fifo_count);
    end

    // Read mux sees pre-edge register values, so a same-cycle write returns the old value.
    always_comb begin
        mmio_d = '0;
        case (req.addr)
            ADDR_LED:  mmio_d = DATA_W'(led);
            ADDR_SW:   mmio_d = DATA_W'(sw_sync);
            ADDR_CNT:  mmio_d = cnt_q;
            ADDR_STAT: mmio_d = stat_word;
            default:   mmio_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            led        <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            mmio_q     <= '0;
            sel_ram_q  <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (wr_led) led <= req.wdata[BYTE_W-1:0];
            cnt_q <= wr_cnt ? '0 : cnt_q + DATA_W'(1);
            // A new overflow outranks a concurrent clear.
            if (fifo_ovf_pulse)  overflow_q <= 1'b1;
            else if (wr_stat)    overflow_q <= 1'b0;
            mmio_q    <= mmio_d;
            sel_ram_q <= sel_ram;
        end
    end

endmodule
